// File: rtl/huffman_freq_count.sv
// Symbol-frequency counter: register-write port -> word FIFO -> byte serialiser -> count table.
// Optional `HUFF_SATURATE_EN: count entries saturate and set a sticky sat flag instead of wrapping.
module huffman_freq_count #(
  parameter int SYM_W      = 7,
  parameter int CNT_W      = 16,
  parameter int SIZE_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sat,
  output logic [SIZE_W-1:0] sym_count,
  input  logic [SYM_W-1:0]  rd_addr,
  output logic [CNT_W-1:0]  rd_data
);

  localparam int LANES   = DATA_W / 8;
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRIES = 2 ** SYM_W;

  localparam logic [AW:0]       PTR_ONE  = 1;
  localparam logic [LW-1:0]     LANE_ONE = 1;
  localparam logic [SIZE_W-1:0] SIZE_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [SIZE_W-1:0] size_q, run_size_q;
  logic [CNT_W-1:0]  cnt_tbl  [ENTRIES];
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] ser_word;
  logic [LW-1:0]     ser_lane;
  logic              ser_valid;

  logic              fifo_empty, fifo_full;
  logic              start, size_wr, data_wr, push, pop, emit, last_lane, reach;
  logic [SYM_W-1:0]  sym;
  logic [SIZE_W-1:0] cnt_next;
  logic [CNT_W-1:0]  entry_next;
`ifdef HUFF_SATURATE_EN
  logic              entry_sat;
  logic              sat_q;
`endif

  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    start      = wr_en && (wr_addr == 2'd0) && wr_data[0];
    size_wr    = wr_en && (wr_addr == 2'd1);
    data_wr    = wr_en && (wr_addr == 2'd2);
    push       = data_wr && (state_q == RUN) && !fifo_full;
    emit       = (state_q == RUN) && ser_valid;
    sym        = ser_word[{ser_lane, 3'b000} +: SYM_W];
    last_lane  = (ser_lane == LW'(LANES - 1));
    cnt_next   = sym_count + SIZE_ONE;
    reach      = emit && (cnt_next == run_size_q);
    // Refill on the last lane's edge as well, so symbols stream without a bubble.
    pop        = (state_q == RUN) && !fifo_empty && (!ser_valid || last_lane) && !reach;
`ifdef HUFF_SATURATE_EN
    entry_sat  = (cnt_tbl[sym] == '1);
    entry_next = entry_sat ? cnt_tbl[sym] : cnt_tbl[sym] + CNT_ONE;
`else
    entry_next = cnt_tbl[sym] + CNT_ONE;
`endif

    state_d = state_q;
    if (clear)      state_d = IDLE;
    else if (start) state_d = (size_q == '0) ? DONE : RUN;
    else if (reach) state_d = DONE;

    wr_ready = (state_q == RUN) && !fifo_full;
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
  end

`ifdef HUFF_SATURATE_EN
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q     <= '0;
      run_size_q <= '0;
      sym_count  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ser_word   <= '0;
      ser_lane   <= '0;
      ser_valid  <= 1'b0;
      err        <= 1'b0;
      rd_data    <= '0;
`ifdef HUFF_SATURATE_EN
      sat_q      <= 1'b0;
`endif
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_tbl[i] <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (clear) begin
      run_size_q <= '0;
      sym_count  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ser_lane   <= '0;
      ser_valid  <= 1'b0;
      err        <= 1'b0;
      rd_data    <= '0;
`ifdef HUFF_SATURATE_EN
      sat_q      <= 1'b0;
`endif
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_tbl[i] <= '0;
    end else begin
      err     <= data_wr && !push;
      rd_data <= cnt_tbl[rd_addr];
      if (size_wr) size_q <= wr_data[SIZE_W-1:0];
      if (start) begin
        run_size_q <= size_q;
        sym_count  <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        ser_lane   <= '0;
        ser_valid  <= 1'b0;
`ifdef HUFF_SATURATE_EN
        sat_q      <= 1'b0;
`endif
        for (int unsigned i = 0; i < ENTRIES; i++) cnt_tbl[i] <= '0;
      end else begin
        if (emit) begin
          cnt_tbl[sym] <= entry_next;
          sym_count    <= cnt_next;
          ser_lane     <= last_lane ? '0 : ser_lane + LANE_ONE;
          if (last_lane) ser_valid <= 1'b0;
`ifdef HUFF_SATURATE_EN
          if (entry_sat) sat_q <= 1'b1;
`endif
        end
        if (reach) begin
          // Final symbol: drop any buffered words and the rest of the current word.
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          ser_valid <= 1'b0;
          ser_lane  <= '0;
        end else begin
          if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr <= wr_ptr + PTR_ONE;
          end
          if (pop) begin
            ser_word  <= fifo_mem[rd_ptr[AW-1:0]];
            ser_lane  <= '0;
            ser_valid <= 1'b1;
            rd_ptr    <= rd_ptr + PTR_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_freq_count.sv
// Self-checking bench for huffman_freq_count: queue-based reference model plus directed literal checks.
module tb_huffman_freq_count;
  localparam int SYM_W = 7, CNT_W = 4, SIZE_W = 16, DATA_W = 32, DEPTH = 4, LANES = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1, clear = 1'b0, wr_en = 1'b0;
  logic [1:0]        wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [SYM_W-1:0]  rd_addr = '0;
  logic              wr_ready, busy, done, err, sat;
  logic [SIZE_W-1:0] sym_count;
  logic [CNT_W-1:0]  rd_data;

  int checks = 0, errors = 0;

  huffman_freq_count #(.SYM_W(SYM_W), .CNT_W(CNT_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W),
                       .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done(done), .err(err),
    .sat(sat), .sym_count(sym_count), .rd_addr(rd_addr), .rd_data(rd_data));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 run, 2 done; FIFO and pending symbols held as queues.
  int                m_st = 0;
  logic [CNT_W-1:0]  m_tbl [2**SYM_W];
  logic [SIZE_W-1:0] m_cnt = '0, m_size = '0, m_run = '0;
  logic [31:0]       m_fifo [$];
  logic [7:0]        m_ser [$];
  logic              m_err = 1'b0, m_sat = 1'b0;
  logic [CNT_W-1:0]  m_rd = '0;

  task automatic model_reset(input bit full);
    m_st = 0;
    foreach (m_tbl[i]) m_tbl[i] = '0;
    m_cnt = '0; m_run = '0;
    if (full) m_size = '0;
    m_fifo.delete(); m_ser.delete();
    m_err = 1'b0; m_sat = 1'b0; m_rd = '0;
  endtask

  task automatic model_step();
    bit dw, acc, reached;
    logic [31:0] w;
    logic [7:0] b;
    dw  = wr_en && wr_addr == 2'd2;
    acc = dw && m_st == 1 && m_fifo.size() < DEPTH;
    m_err = dw && !acc;
    m_rd  = m_tbl[rd_addr];
    if (wr_en && wr_addr == 2'd1) m_size = wr_data[SIZE_W-1:0];
    if (wr_en && wr_addr == 2'd0 && wr_data[0]) begin
      foreach (m_tbl[i]) m_tbl[i] = '0;
      m_cnt = '0; m_fifo.delete(); m_ser.delete(); m_sat = 1'b0;
      m_run = m_size;
      m_st  = (m_size == 0) ? 2 : 1;
    end else if (m_st == 1) begin
      reached = 0;
      if (m_ser.size() > 0) begin
        b = m_ser.pop_front();
`ifdef HUFF_SATURATE_EN
        if (m_tbl[b[SYM_W-1:0]] == {CNT_W{1'b1}}) m_sat = 1'b1;
        else m_tbl[b[SYM_W-1:0]] = m_tbl[b[SYM_W-1:0]] + 1'b1;
`else
        m_tbl[b[SYM_W-1:0]] = m_tbl[b[SYM_W-1:0]] + 1'b1;
`endif
        m_cnt = m_cnt + 1'b1;
        if (m_cnt == m_run) reached = 1;
      end
      if (reached) begin
        m_st = 2; m_fifo.delete(); m_ser.delete();
      end else begin
        if (m_ser.size() == 0 && m_fifo.size() > 0) begin
          w = m_fifo.pop_front();
          for (int k = 0; k < LANES; k++) m_ser.push_back(w[8*k +: 8]);
        end
        if (acc) m_fifo.push_back(wr_data);
      end
    end
  endtask

  initial foreach (m_tbl[i]) m_tbl[i] = '0;

  always @(posedge clk or posedge reset) begin
    if (reset)      model_reset(1);
    else if (clear) model_reset(0);
    else            model_step();
  end

  always @(negedge clk) begin
    chk("wr_ready", wr_ready, (m_st == 1 && m_fifo.size() < DEPTH));
    chk("busy", busy, m_st == 1);
    chk("done", done, m_st == 2);
    chk("err", err, m_err);
    chk("sat", sat, m_sat);
    chk("sym_count", sym_count, m_cnt);
    chk("rd_data", rd_data, m_rd);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a, output logic [CNT_W-1:0] v);
    rd_addr = SYM_W'(a);
    cyc();
    v = rd_data;
  endtask

  task automatic run_start(input int sz);
    put(2'd1, 32'(sz));
    put(2'd0, 32'h1);
  endtask

  initial begin
    logic [CNT_W-1:0] v;
    logic             rdy [7];
    int               act, sz;
    logic [7:0]       b;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ready", wr_ready, 0);
    chk("rst_cnt", sym_count, 0); chk("rst_rd", rd_data, 0);

    // Run 1
    run_start(4);
    put(2'd2, 32'h0C140003);
    repeat (4) cyc();
    chk("t1_done_early", done, 0); chk("t1_cnt3", sym_count, 3);
    cyc();
    chk("t1_done", done, 1); chk("t1_cnt", sym_count, 4);
    rd(3, v);  chk("t1_c3", v, 1);
    rd(0, v);  chk("t1_c0", v, 1);
    rd(20, v); chk("t1_c20", v, 1);
    rd(12, v); chk("t1_c12", v, 1);
    rd(1, v);  chk("t1_c1", v, 0);

    // Run 2: table re-zeroed
    run_start(4);
    put(2'd2, 32'h0C090008);
    repeat (6) cyc();
    chk("t2_done", done, 1);
    rd(8, v);  chk("t2_c8", v, 1);
    rd(9, v);  chk("t2_c9", v, 1);
    rd(12, v); chk("t2_c12", v, 1);
    rd(0, v);  chk("t2_c0", v, 1);
    rd(3, v);  chk("t2_c3", v, 0);
    rd(20, v); chk("t2_c20", v, 0);

    // Run 3: two words
    run_start(6);
    put(2'd2, 32'h04030201);
    put(2'd2, 32'h08070605);
    repeat (8) cyc();
    chk("t3_done", done, 1); chk("t3_cnt", sym_count, 6);
    for (int i = 1; i <= 6; i++) begin rd(i, v); chk("t3_c", v, 1); end
    rd(7, v); chk("t3_c7", v, 0);
    rd(8, v); chk("t3_c8", v, 0);

    // Backpressure
    run_start(100);
    for (int i = 0; i < 7; i++) begin
      rdy[i] = wr_ready;
      put(2'd2, $urandom);
      if (i == 5) chk("t4_err6", err, 1);
    end
    for (int i = 0; i < 5; i++) chk("t4_ready", rdy[i], 1);
    chk("t4_ready6", rdy[5], 0);
    clear = 1'b1; cyc(); clear = 1'b0;
    put(2'd2, 32'h1234);
    chk("t4_idle_err", err, 1);
    cyc();
    chk("t4_err_pulse", err, 0);

    // Count overflow
    run_start(20);
    repeat (5) put(2'd2, 32'h05050505);
    repeat (20) cyc();
    chk("t5_done", done, 1);
    rd(5, v);
`ifdef HUFF_SATURATE_EN
    chk("t5_c5", v, 15); chk("t5_sat", sat, 1);
`else
    chk("t5_c5", v, 4);  chk("t5_sat", sat, 0);
`endif

    // Async reset mid-run
    run_start(4);
    put(2'd2, 32'h07070707);
    repeat (3) cyc();
    chk("t6_cnt2", sym_count, 2);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", busy, 0); chk("t6_done", done, 0); chk("t6_cnt", sym_count, 0);
    chk("t6_rd", rd_data, 0); chk("t6_ready", wr_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    run_start(4);
    put(2'd2, 32'h01010102);
    repeat (6) cyc();
    chk("t6_done2", done, 1);
    rd(1, v); chk("t6_c1", v, 3);
    rd(2, v); chk("t6_c2", v, 1);
    rd(7, v); chk("t6_c7", v, 0);

    // Randomised traffic checked by the model every cycle
    for (int r = 0; r < 25; r++) begin
      sz = (r % 7 == 3) ? 0 : int'($urandom_range(1, 60));
      run_start(sz);
      for (int c = 0; c < 120; c++) begin
        act = int'($urandom_range(0, 99));
        rd_addr = SYM_W'($urandom);
        b = 8'($urandom_range(0, 3));
        if (act < 55) begin
          wr_en = 1'b1; wr_addr = 2'd2;
          wr_data = (act < 25) ? {4{b}} : $urandom;
        end else if (act < 58) begin
          wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'($urandom_range(0, 40));
        end else if (act < 60) begin
          wr_en = 1'b1; wr_addr = 2'd0; wr_data = $urandom | 32'h1;
        end else if (act < 63) begin
          wr_en = 1'b1; wr_addr = 2'd0; wr_data = $urandom & 32'hFFFF_FFFE;
        end else if (act < 66) begin
          wr_en = 1'b1; wr_addr = 2'd3; wr_data = $urandom;
        end else if (act == 66) begin
          clear = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = $urandom;
        end
        cyc();
        wr_en = 1'b0; clear = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/huffman_freq_count.md
# huffman_freq_count

Parametrised symbol-frequency counter for the Huffman encoder front end. Accepts a start command, a symbol count and a stream of packed data words over a simple register-write port. Data words are buffered in a small FIFO and serialised to one symbol per cycle into a per-symbol count table, with a registered read-back port. It feeds the tree builder and generalises the fixed 128×16 counter: symbol width, count width, bus width and buffer depth are parametrised, with backpressure, error reporting and optional saturation added.

## Interface
- SYM_W, 7, symbol width; the table has 2**SYM_W entries
- CNT_W, 16, width of each count entry
- SIZE_W, 16, width of the SIZE register and of sym_count
- DATA_W, 32, write-data width; must be a multiple of 8; LANES = DATA_W/8
- FIFO_DEPTH, 4, data-word FIFO depth; power of 2, ≥2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous soft clear
- wr_en  in  1  register write strobe
- wr_addr  in  2  0 = CTRL (bit0 = start), 1 = SIZE, 2 = DATA, 3 = reserved (write ignored, no error)
- wr_data  in  DATA_W  write data
- wr_ready  out  1  a DATA write is accepted this cycle
- busy  out  1  state is RUN
- done  out  1  level; SIZE symbols have been counted
- err  out  1  one-cycle pulse when a write is dropped
- sat  out  1  sticky; a count saturated (HUFF_SATURATE_EN only)
- sym_count  out  SIZE_W  symbols counted since start
- rd_addr  in  SYM_W  count-table read index
- rd_data  out  CNT_W  registered count[rd_addr]

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE. All outputs are 0 at reset; the table, SIZE, FIFO and sym_count are zeroed.
- SIZE write: latches wr_data[SIZE_W-1:0] in any state. It is used at the next start.
- start (CTRL write with bit0 = 1), in any state:
  - zeroes the table, sym_count, FIFO, serialiser and sat;
  - goes to RUN, or directly to DONE if SIZE = 0.
  - A start during RUN restarts the run.
- DATA write in RUN with wr_ready = 1: pushes the word into the FIFO.
- wr_ready = 1 only in RUN when the FIFO is not full.
- DATA write that is dropped raises an err pulse. A write is dropped when it arrives in IDLE or DONE, or in RUN with the FIFO full.
- Serialiser: pops one word when it is empty and the FIFO is non-empty. It emits lane 0 (wr_data[7:0]) first, one lane per cycle.
- Symbol value = byte[SYM_W-1:0]; higher bits of the byte are ignored.
- Each emitted symbol increments count[sym] by 1 and sym_count by 1.
- When sym_count reaches SIZE:
  - the state goes to DONE at the same edge;
  - remaining lanes and FIFO contents are discarded;
  - done = 1 until the next start, clear or reset.
- clear: same effect as reset, except SIZE is kept.
- Priority: reset > clear > start > DATA write. Writes in the clear cycle are ignored.
- Count overflow without the macro wraps modulo 2**CNT_W.

## Timing
- DATA write at edge t, with FIFO empty and serialiser idle:
  - word visible in the FIFO after t;
  - popped at t+1;
  - lane k counted at edge t+2+k.
- Throughput is one symbol per cycle. Sustained DATA writes get wr_ready = 0 once the FIFO fills (LANES > 1).
- done and busy change at the same edge as the final increment.
- rd_data updates every edge from the pre-edge table. A read of an index updated at that edge returns the old value.
- err is asserted the cycle after the offending write.
- Reset asserted mid-run aborts immediately. All state is as at power-on.

## Configuration
- HUFF_SATURATE_EN defined: an increment of an entry at 2**CNT_W−1 holds it there and sets sat (sticky until start/clear/reset).
- HUFF_SATURATE_EN not defined: entries wrap to 0; sat is tied to 0.

## Test plan
- Reset, then SIZE = 4, start, DATA 0x0C140003:
  - count[3], count[0], count[20], count[12] = 1; all other entries 0;
  - sym_count = 4, done = 1 at write edge + 5.
- Second run, SIZE = 4, start, DATA 0x0C090008:
  - count[8], count[9], count[12] = 1 and count[0] = 1 (table re-zeroed);
  - count[3] and count[20] = 0.
- SIZE = 6, start, DATA 0x04030201 then 0x08070605:
  - counts 1..6 = 1; count[7] and count[8] = 0;
  - done after the 6th symbol; FIFO is empty.
- FIFO_DEPTH = 4, SIZE = 100, start, 7 back-to-back DATA writes:
  - wr_ready drops after the 5th accept;
  - the 6th write is dropped with an err pulse;
  - a DATA write in IDLE also gives an err pulse.
- CNT_W = 4, SIZE = 20, five words of 0x05050505:
  - with HUFF_SATURATE_EN: count[5] = 15, sat = 1;
  - without: count[5] = 4, sat = 0.
- Assert reset after 2 symbols of a run: all outputs 0, state IDLE; a following run with SIZE = 4 gives correct counts.
